// File: rtl/mc_ctrl_fsm_if.sv
// mc_ctrl_fsm_if: control bundle between the multicycle control FSM and the
// register/IR datapath.
//   master (FSM side) : receives op_in, fn_in, alu_zero, mem_ready;
//                       drives every datapath enable/select, state_out,
//                       bus_err and trap.
//   slave (datapath)  : the mirror image.
interface mc_ctrl_fsm_if;
   logic [5:0] op_in;
   logic [5:0] fn_in;
   logic       alu_zero;
   logic       mem_ready;

   logic       IRWrite;
   logic       RegWrite;
   logic [1:0] RegDst;
   logic       RegInSrc;
   logic       DRegSel0;
   logic       DRegSel1;
   logic       PCWrite;
   logic [1:0] PCSrc;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [2:0] ALUCtl;
   logic [3:0] state_out;
   logic       bus_err;
   logic       trap;

   modport master (
      input  op_in, fn_in, alu_zero, mem_ready,
      output IRWrite, RegWrite, RegDst, RegInSrc, DRegSel0, DRegSel1,
             PCWrite, PCSrc, IorD, MemRead, MemWrite,
             ALUSrcA, ALUSrcB, ALUCtl, state_out, bus_err, trap
   );

   modport slave (
      output op_in, fn_in, alu_zero, mem_ready,
      input  IRWrite, RegWrite, RegDst, RegInSrc, DRegSel0, DRegSel1,
             PCWrite, PCSrc, IorD, MemRead, MemWrite,
             ALUSrcA, ALUSrcB, ALUCtl, state_out, bus_err, trap
   );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle control FSM for the register/IR datapath.
// Sequences fetch, decode, execute, memory access and write-back, and emits
// every per-cycle enable for IR, register file, PC, ALU and memory select.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high; returns to FETCH, clears flags
//   bus    : mc_ctrl_fsm_if.master (op/fn/alu_zero/mem_ready in, controls out)
// Parameter TIMEOUT (1..255): cycles spent waiting for mem_ready in FETCH,
// MEM_RD or MEM_WR before the FSM halts with bus_err set.
// RegDst=2'b10 always selects R31 as the jal return-address register.
// Compile-time option ILLEGAL_TRAP_EN: when defined, an illegal op/fn parks
// the FSM in TRAP and sets the sticky trap flag; when undefined, an illegal
// instruction is retired as a NOP and trap is tied low.
// Enables are decoded combinationally from state (plus mem_ready in FETCH and
// alu_zero in BRANCH) so the datapath sees them in the same cycle.
module mc_ctrl_fsm #(
   parameter int unsigned TIMEOUT = 16
) (
   input logic           clk,
   input logic           reset,
   mc_ctrl_fsm_if.master bus
);

   localparam int unsigned CNT_W = 8;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_JAL   = 6'd3;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;

   localparam logic [5:0] FN_JR  = 6'd8;
   localparam logic [5:0] FN_ADD = 6'd32;
   localparam logic [5:0] FN_SUB = 6'd34;
   localparam logic [5:0] FN_AND = 6'd36;
   localparam logic [5:0] FN_OR  = 6'd37;
   localparam logic [5:0] FN_SLT = 6'd42;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;

   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      R_EXEC   = 4'd2,
      ALU_WB   = 4'd3,
      I_EXEC   = 4'd4,
      MEM_ADDR = 4'd5,
      MEM_RD   = 4'd6,
      MEM_WB   = 4'd7,
      MEM_WR   = 4'd8,
      BRANCH   = 4'd9,
      JUMP     = 4'd10,
      HALT     = 4'd11,
      TRAP     = 4'd12
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] wait_cnt;
   logic             bus_err_q;
   logic             waiting_c;
   logic             timeout_c;
   logic             r_legal_c;
   logic [2:0]       r_alu_c;

   // ALU function for R-type instructions, decoded from the funct field
   always_comb begin
      r_legal_c = 1'b1;
      r_alu_c   = ALU_ADD;
      case (bus.fn_in)
         FN_ADD:  r_alu_c = ALU_ADD;
         FN_SUB:  r_alu_c = ALU_SUB;
         FN_AND:  r_alu_c = ALU_AND;
         FN_OR:   r_alu_c = ALU_OR;
         FN_SLT:  r_alu_c = ALU_SLT;
         default: r_legal_c = 1'b0;
      endcase
   end

   // Memory-wait states and the timeout condition; mem_ready on the last
   // allowed cycle still completes normally
   assign waiting_c = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
   assign timeout_c = waiting_c && !bus.mem_ready && (wait_cnt == WAIT_LAST);

   // State register, wait counter and sticky flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= FETCH;
         wait_cnt  <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state) begin
            wait_cnt <= '0;
         end else if (waiting_c && !bus.mem_ready) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end
         if (timeout_c) begin
            bus_err_q <= 1'b1;
         end
      end
   end

`ifdef ILLEGAL_TRAP_EN
   logic trap_q;

   // Sticky illegal-instruction flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         trap_q <= 1'b0;
      end else if (state_nxt == TRAP) begin
         trap_q <= 1'b1;
      end
   end

   assign bus.trap = trap_q;
`else
   assign bus.trap = 1'b0;
`endif

   assign bus.state_out = state;
   assign bus.bus_err   = bus_err_q;
   assign bus.DRegSel0  = 1'b0;
   assign bus.DRegSel1  = 1'b0;

   // Next-state and per-state control decode
   always_comb begin
      state_nxt    = state;
      bus.IRWrite  = 1'b0;
      bus.RegWrite = 1'b0;
      bus.RegDst   = 2'b00;
      bus.RegInSrc = 1'b0;
      bus.PCWrite  = 1'b0;
      bus.PCSrc    = 2'b00;
      bus.IorD     = 1'b0;
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
      bus.ALUSrcA  = 1'b0;
      bus.ALUSrcB  = 2'b00;
      bus.ALUCtl   = ALU_ADD;

      case (state)
         FETCH: begin
            bus.MemRead = 1'b1;
            bus.ALUSrcB = 2'b01;
            if (bus.mem_ready) begin
               bus.IRWrite = 1'b1;
               bus.PCWrite = 1'b1;
               state_nxt   = DECODE;
            end else if (timeout_c) begin
               state_nxt = HALT;
            end
         end

         DECODE: begin
            bus.ALUSrcB = 2'b11;
            case (bus.op_in)
               OP_RTYPE: begin
                  if (r_legal_c) begin
                     state_nxt = R_EXEC;
                  end else if (bus.fn_in == FN_JR) begin
                     state_nxt = JUMP;
                  end else begin
`ifdef ILLEGAL_TRAP_EN
                     state_nxt = TRAP;
`else
                     state_nxt = FETCH;
`endif
                  end
               end
               OP_LW, OP_SW: state_nxt = MEM_ADDR;
               OP_ADDI:      state_nxt = I_EXEC;
               OP_BEQ:       state_nxt = BRANCH;
               OP_J, OP_JAL: state_nxt = JUMP;
               default: begin
`ifdef ILLEGAL_TRAP_EN
                  state_nxt = TRAP;
`else
                  state_nxt = FETCH;
`endif
               end
            endcase
         end

         R_EXEC: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUCtl  = r_alu_c;
            state_nxt   = ALU_WB;
         end

         I_EXEC: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = 2'b10;
            state_nxt   = ALU_WB;
         end

         // ALU controls repeat those of R_EXEC / I_EXEC, chosen by the opcode
         ALU_WB: begin
            bus.RegWrite = 1'b1;
            bus.RegInSrc = 1'b1;
            bus.ALUSrcA  = 1'b1;
            if (bus.op_in == OP_RTYPE) begin
               bus.RegDst = 2'b01;
               bus.ALUCtl = r_alu_c;
            end else begin
               bus.ALUSrcB = 2'b10;
            end
            state_nxt = FETCH;
         end

         MEM_ADDR: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = 2'b10;
            state_nxt   = (bus.op_in == OP_SW) ? MEM_WR : MEM_RD;
         end

         MEM_RD: begin
            bus.MemRead = 1'b1;
            bus.IorD    = 1'b1;
            if (bus.mem_ready) begin
               state_nxt = MEM_WB;
            end else if (timeout_c) begin
               state_nxt = HALT;
            end
         end

         MEM_WB: begin
            bus.RegWrite = 1'b1;
            state_nxt    = FETCH;
         end

         MEM_WR: begin
            bus.MemWrite = 1'b1;
            bus.IorD     = 1'b1;
            if (bus.mem_ready) begin
               state_nxt = FETCH;
            end else if (timeout_c) begin
               state_nxt = HALT;
            end
         end

         BRANCH: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUCtl  = ALU_SUB;
            bus.PCWrite = bus.alu_zero;
            bus.PCSrc   = 2'b01;
            state_nxt   = FETCH;
         end

         // jr takes rs_data; j/jal take the pseudo-direct target; jal links R31
         JUMP: begin
            bus.PCWrite = 1'b1;
            bus.PCSrc   = (bus.op_in == OP_RTYPE) ? 2'b11 : 2'b10;
            if (bus.op_in == OP_JAL) begin
               bus.RegWrite = 1'b1;
               bus.RegDst   = 2'b10;
               bus.RegInSrc = 1'b1;
            end
            state_nxt = FETCH;
         end

         HALT, TRAP: state_nxt = state;

         default: state_nxt = FETCH;
      endcase

      // Keep write strobes low while reset is asserted
      if (reset) begin
         bus.IRWrite  = 1'b0;
         bus.RegWrite = 1'b0;
         bus.PCWrite  = 1'b0;
         bus.MemWrite = 1'b0;
      end
   end

endmodule
